// File: rtl/counter_pkg.sv
// Shared types and helpers for the synchronous modulo counter family.
// Optional Gray output of sync_mod_counter is enabled by SYNC_MOD_COUNTER_GRAY_EN.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Binary to reflected Gray code; callers cast the result to their width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Ceiling log2 that never returns 0, so a 1-entry range still gets a 1-bit register.
    function automatic int unsigned safe_clog2(input int unsigned value);
        int unsigned result;
        result = $clog2(value);
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Divides qualifying en cycles by PRESCALE; tick marks the en cycle that completes a period.
// Part of sync_mod_counter (optional Gray output via SYNC_MOD_COUNTER_GRAY_EN).
module cnt_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PRE_W = safe_clog2(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre;

    assign tick = en && (pre == PRE_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre <= '0;
        end else if (clr) begin
            pre <= '0;
        end else if (en) begin
            pre <= (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
        end
    end

endmodule

// File: rtl/sync_mod_counter.sv
// Synchronous modulo counter with prescaler, up/down, parallel load and wrap/saturate modes.
// Define SYNC_MOD_COUNTER_GRAY_EN to add a registered Gray-coded copy of the count.
module sync_mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
`ifdef SYNC_MOD_COUNTER_GRAY_EN
    output logic [WIDTH-1:0] count_gray,
`endif
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("sync_mod_counter: WIDTH must be in 1..32");
        end
        if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
            $error("sync_mod_counter: MODULUS must be in 2..2**WIDTH");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("sync_mod_counter: PRESCALE must be at least 1");
        end
    endgenerate

    logic             tick;
    logic             step;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;

    cnt_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .clr  (load),
        .tick (tick)
    );

    // Load discards any step that fires in the same cycle.
    assign step = tick && !load;

    assign tc = (up == DIR_UP) ? (count == TERM) : (count == '0);

    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        if (load) begin
            count_nxt = (load_val > TERM) ? TERM : load_val;
        end else if (step) begin
            if (up == DIR_UP) begin
                if (count != TERM) begin
                    count_nxt = count + WIDTH'(1);
                end else if (!sat) begin
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
                end
            end else begin
                if (count != '0) begin
                    count_nxt = count - WIDTH'(1);
                end else if (!sat) begin
                    count_nxt = TERM;
                    wrap_nxt  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
        end
    end

`ifdef SYNC_MOD_COUNTER_GRAY_EN
    // Gray copy is encoded from the next value so it lands on the same edge as count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_gray <= '0;
        end else begin
            count_gray <= WIDTH'(bin2gray(32'(count_nxt)));
        end
    end
`endif

endmodule
